// File: rtl/gray_seq_pkg.sv
// rtl/gray_seq_pkg.sv - shared types and Gray-to-binary helper for the Gray sequence decoder
package gray_seq_pkg;

  localparam int GRAY_BITS = 3;

  typedef enum logic [1:0] {IDLE, LOCKED, FAULT} state_t;
  typedef enum logic [1:0] {HOLD, UP, DOWN, ILLEGAL} step_cls_t;

  function automatic logic [GRAY_BITS-1:0] gray2bin(input logic [GRAY_BITS-1:0] g);
    logic [GRAY_BITS-1:0] b;
    b[GRAY_BITS-1] = g[GRAY_BITS-1];
    for (int i = GRAY_BITS - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_seq_classify.sv
// rtl/gray_seq_classify.sv - classifies a code transition as hold, up, down or illegal
module gray_seq_classify
  import gray_seq_pkg::*;
(
  input  logic [GRAY_BITS-1:0] prev_code,
  input  logic [GRAY_BITS-1:0] code,
  output logic [1:0]           cls
);

  logic [GRAY_BITS-1:0] diff;

  // Any multi-bit change in a reflected Gray cycle also moves more than one index,
  // so the modular index difference alone decides legality.
  always_comb begin
    diff = gray2bin(code) - gray2bin(prev_code);
    case (diff)
      3'd0:    cls = HOLD;
      3'd1:    cls = UP;
      3'd7:    cls = DOWN;
      default: cls = ILLEGAL;
    endcase
  end

endmodule

// File: rtl/gray_seq_decoder.sv
// rtl/gray_seq_decoder.sv - Gray sequence decoder top; GRAY_SEQ_ERRCNT_EN adds err_count
module gray_seq_decoder
  import gray_seq_pkg::*;
#(
  parameter int POS_W      = 8,
  parameter int RELOCK_CNT = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 code_valid,
  input  logic [GRAY_BITS-1:0] code_in,
  output logic                 locked,
  output logic                 step,
  output logic                 dir,
  output logic [POS_W-1:0]     position,
  output logic [GRAY_BITS-1:0] index,
  output logic                 err
`ifdef GRAY_SEQ_ERRCNT_EN
  ,
  output logic [7:0]           err_count
`endif
);

  state_t               state, state_n;
  logic [GRAY_BITS-1:0] prev_code, prev_n;
  logic [3:0]           cnt, cnt_n;
  logic                 step_n, dir_n, err_n;
  logic [POS_W-1:0]     pos_n;
  logic [GRAY_BITS-1:0] idx_n;
  logic [1:0]           cls_raw;
  step_cls_t            cls;

  gray_seq_classify u_classify (
    .prev_code (prev_code),
    .code      (code_in),
    .cls       (cls_raw)
  );

  assign cls    = step_cls_t'(cls_raw);
  assign locked = (state == LOCKED);

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      prev_code <= '0;
      cnt       <= '0;
      step      <= 1'b0;
      dir       <= 1'b1;
      position  <= '0;
      index     <= '0;
      err       <= 1'b0;
    end else begin
      state     <= state_n;
      prev_code <= prev_n;
      cnt       <= cnt_n;
      step      <= step_n;
      dir       <= dir_n;
      position  <= pos_n;
      index     <= idx_n;
      err       <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    prev_n  = prev_code;
    cnt_n   = cnt;
    step_n  = 1'b0;
    err_n   = 1'b0;
    dir_n   = dir;
    pos_n   = position;
    idx_n   = index;
    if (code_valid) begin
      prev_n = code_in;
      idx_n  = gray2bin(code_in);
      case (state)
        IDLE: begin
          pos_n   = '0;
          state_n = LOCKED;
        end
        LOCKED: begin
          case (cls)
            UP: begin
              step_n = 1'b1;
              dir_n  = 1'b1;
              pos_n  = position + POS_W'(1);
            end
            DOWN: begin
              step_n = 1'b1;
              dir_n  = 1'b0;
              pos_n  = position - POS_W'(1);
            end
            ILLEGAL: begin
              err_n   = 1'b1;
              state_n = FAULT;
              cnt_n   = '0;
            end
            default: ;
          endcase
        end
        FAULT: begin
          // Relock happens on the sample that completes the run; it never steps.
          if (cls == ILLEGAL) begin
            err_n = 1'b1;
            cnt_n = '0;
          end else if (cnt + 4'd1 == 4'(RELOCK_CNT)) begin
            state_n = LOCKED;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + 4'd1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

`ifdef GRAY_SEQ_ERRCNT_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      err_count <= '0;
    end else if (err_n && err_count != 8'hFF) begin
      err_count <= err_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_gray_seq_decoder.sv
// tb/tb_gray_seq_decoder.sv - scoreboard bench for gray_seq_decoder (POS_W=8 and POS_W=4)
`timescale 1ns/1ps
module tb_gray_seq_decoder;

  typedef struct packed {
    logic       locked;
    logic       step;
    logic       dir;
    logic [7:0] position;
    logic [2:0] index;
    logic       err;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset;
  logic       code_valid, code_valid4;
  logic [2:0] code_in, code_in4;
  logic       locked, step, dir, err;
  logic [7:0] position;
  logic [2:0] index;
  logic       locked4, step4, dir4, err4;
  logic [3:0] position4;
  logic [2:0] index4;
`ifdef GRAY_SEQ_ERRCNT_EN
  logic [7:0] err_count, err_count4;
`endif

  exp_t       sb[$];
  exp_t       got, e;
  int         errors = 0;
  int         checks = 0;
  logic [2:0] gray_tab [8] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};

  always #5 clock = ~clock;

  gray_seq_decoder #(.POS_W(8), .RELOCK_CNT(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .code_valid (code_valid),
    .code_in    (code_in),
    .locked     (locked),
    .step       (step),
    .dir        (dir),
    .position   (position),
    .index      (index),
    .err        (err)
`ifdef GRAY_SEQ_ERRCNT_EN
    ,
    .err_count  (err_count)
`endif
  );

  gray_seq_decoder #(.POS_W(4), .RELOCK_CNT(4)) dut4 (
    .clock      (clock),
    .reset      (reset),
    .code_valid (code_valid4),
    .code_in    (code_in4),
    .locked     (locked4),
    .step       (step4),
    .dir        (dir4),
    .position   (position4),
    .index      (index4),
    .err        (err4)
`ifdef GRAY_SEQ_ERRCNT_EN
    ,
    .err_count  (err_count4)
`endif
  );

  function automatic exp_t mk(logic lk, logic st, logic dr, logic [7:0] pos, logic [2:0] idx, logic er);
    return '{locked: lk, step: st, dir: dr, position: pos, index: idx, err: er};
  endfunction

  function automatic exp_t obs8();
    return '{locked: locked, step: step, dir: dir, position: position, index: index, err: err};
  endfunction

  function automatic exp_t obs4();
    return '{locked: locked4, step: step4, dir: dir4, position: {4'b0, position4}, index: index4, err: err4};
  endfunction

  task automatic drive(input logic r, input logic v, input logic [2:0] c);
    reset      = r;
    code_valid = v;
    code_in    = c;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b0, 3'b000);
    sb.push_back(mk(0, 0, 1, 8'd0, 3'd0, 0));
    tick();
    got = obs8(); e = sb.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL reset: got {lk,st,dir,pos,idx,err}=%h expected %h", got, e); end
  endtask

  task automatic test_first_lock();
    drive(1'b0, 1'b0, 3'b000);
    sb.push_back(mk(0, 0, 1, 8'd0, 3'd0, 0));
    drive(1'b0, 1'b1, 3'b000);
    sb.push_back(mk(1, 0, 1, 8'd0, 3'd0, 0));
    drive(1'b0, 1'b0, 3'b000);
    sb.push_back(mk(1, 0, 1, 8'd0, 3'd0, 0));
    // queue holds the three expected rows; drive them again in order against the clock
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, k == 1, 3'b000);
      tick();
      got = obs8(); e = sb.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL first_lock[%0d]: got %h expected %h", k, got, e); end
    end
  endtask

  task automatic test_up_sweep();
    for (int i = 1; i <= 8; i++) begin
      drive(1'b0, 1'b1, gray_tab[i % 8]);
      sb.push_back(mk(1, 1, 1, 8'(i), 3'(i % 8), 0));
      tick();
      got = obs8(); e = sb.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL up_sweep[%0d]: got %h expected %h", i, got, e); end
    end
    drive(1'b0, 1'b0, 3'b000);
    sb.push_back(mk(1, 0, 1, 8'd8, 3'd0, 0));
    tick();
    got = obs8(); e = sb.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL up_sweep_idle: got %h expected %h", got, e); end
  endtask

  task automatic test_down();
    logic       r [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic [2:0] c [4] = '{3'b000, 3'b000, 3'b100, 3'b101};
    sb.push_back(mk(0, 0, 1, 8'd0, 3'd0, 0));
    sb.push_back(mk(1, 0, 1, 8'd0, 3'd0, 0));
    sb.push_back(mk(1, 1, 0, 8'hFF, 3'd7, 0));
    sb.push_back(mk(1, 1, 0, 8'hFE, 3'd6, 0));
    for (int k = 0; k < 4; k++) begin
      drive(r[k], 1'b1, c[k]);
      tick();
      got = obs8(); e = sb.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL down[%0d]: got %h expected %h", k, got, e); end
    end
  endtask

  task automatic test_fault_relock();
    logic       r [11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [2:0] c [11] = '{3'b000, 3'b000, 3'b001, 3'b111, 3'b111, 3'b001,
                           3'b001, 3'b011, 3'b010, 3'b011, 3'b001};
    sb.push_back(mk(0, 0, 1, 8'd0, 3'd0, 0));
    sb.push_back(mk(1, 0, 1, 8'd0, 3'd0, 0));
    sb.push_back(mk(1, 1, 1, 8'd1, 3'd1, 0));
    sb.push_back(mk(0, 0, 1, 8'd1, 3'd5, 1));
    sb.push_back(mk(0, 0, 1, 8'd1, 3'd5, 0));
    sb.push_back(mk(0, 0, 1, 8'd1, 3'd1, 1));
    sb.push_back(mk(0, 0, 1, 8'd1, 3'd1, 0));
    sb.push_back(mk(0, 0, 1, 8'd1, 3'd2, 0));
    sb.push_back(mk(0, 0, 1, 8'd1, 3'd3, 0));
    sb.push_back(mk(1, 0, 1, 8'd1, 3'd2, 0));
    sb.push_back(mk(1, 1, 0, 8'd0, 3'd1, 0));
    for (int k = 0; k < 11; k++) begin
      drive(r[k], 1'b1, c[k]);
      tick();
      got = obs8(); e = sb.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL fault_relock[%0d]: got %h expected %h", k, got, e); end
    end
  endtask

  task automatic test_wrap_pos4();
    drive(1'b1, 1'b0, 3'b000);
    code_valid4 = 1'b0;
    tick();
    drive(1'b0, 1'b0, 3'b000);
    sb.push_back(mk(1, 0, 1, 8'd0, 3'd0, 0));
    for (int i = 1; i <= 7; i++) sb.push_back(mk(1, 1, 1, 8'(i), 3'(i), 0));
    sb.push_back(mk(1, 1, 1, 8'h08, 3'd0, 0));
    sb.push_back(mk(1, 1, 0, 8'h07, 3'd7, 0));
    sb.push_back(mk(1, 0, 0, 8'h07, 3'd7, 0));
    sb.push_back(mk(1, 0, 0, 8'h07, 3'd7, 0));
    for (int k = 0; k < 12; k++) begin
      code_valid4 = 1'b1;
      code_in4    = (k <= 7) ? gray_tab[k] : (k == 8) ? 3'b000 : 3'b100;
      tick();
      got = obs4(); e = sb.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL wrap_pos4[%0d]: got %h expected %h", k, got, e); end
    end
    code_valid4 = 1'b0;
  endtask

  task automatic test_reset_override();
    logic       r [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic       v [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [2:0] c [6] = '{3'b000, 3'b000, 3'b001, 3'b110, 3'b000, 3'b110};
    sb.push_back(mk(0, 0, 1, 8'd0, 3'd0, 0));
    sb.push_back(mk(1, 0, 1, 8'd0, 3'd0, 0));
    sb.push_back(mk(1, 1, 1, 8'd1, 3'd1, 0));
    sb.push_back(mk(0, 0, 1, 8'd0, 3'd0, 0));
    sb.push_back(mk(0, 0, 1, 8'd0, 3'd0, 0));
    sb.push_back(mk(1, 0, 1, 8'd0, 3'd4, 0));
    for (int k = 0; k < 6; k++) begin
      drive(r[k], v[k], c[k]);
      tick();
      got = obs8(); e = sb.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL reset_override[%0d]: got %h expected %h", k, got, e); end
    end
  endtask

`ifdef GRAY_SEQ_ERRCNT_EN
  task automatic test_err_count();
    drive(1'b1, 1'b0, 3'b000);
    tick();
    checks++;
    if (err_count !== 8'd0) begin errors++; $display("FAIL err_count_reset: got %0d expected 0", err_count); end
    drive(1'b0, 1'b1, 3'b000);
    tick();
    for (int k = 0; k < 150; k++) begin
      drive(1'b0, 1'b1, 3'b110);
      tick();
      drive(1'b0, 1'b1, 3'b000);
      tick();
      if (k == 4) begin
        checks++;
        if (err_count !== 8'd10) begin errors++; $display("FAIL err_count_10: got %0d expected 10", err_count); end
      end
    end
    checks++;
    if (err_count !== 8'd255) begin errors++; $display("FAIL err_count_sat: got %0d expected 255", err_count); end
    drive(1'b1, 1'b1, 3'b110);
    tick();
    checks++;
    if (err_count !== 8'd0) begin errors++; $display("FAIL err_count_clear: got %0d expected 0", err_count); end
  endtask
`endif

  initial begin
    reset       = 1'b1;
    code_valid  = 1'b0;
    code_in     = 3'b000;
    code_valid4 = 1'b0;
    code_in4    = 3'b000;
    test_reset();
    test_first_lock();
    test_up_sweep();
    test_down();
    test_fault_relock();
    test_wrap_pos4();
    test_reset_override();
`ifdef GRAY_SEQ_ERRCNT_EN
    test_err_count();
`endif
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d leftover entries expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
